// File: rtl/segscan_decoder.sv
// -----------------------------------------------------------------------------
// segscan_decoder
//
// Receive-side decoder for a multiplexed 4-digit 7-segment bus. It samples the
// scanned anode/segment lines, turns each segment pattern back into a digit,
// assembles complete 4-digit frames and converts each frame to binary. A value
// is published only after it has been seen in STABLE_FRAMES consecutive good
// frames.
//
// Parameters
//   SEG_LAG        clocks by which seg trails the anode code it belongs to (0..3)
//   STABLE_FRAMES  consecutive identical good frames needed to publish (1..15)
//
// Ports
//   myclk    in   1   system clock, posedge
//   rst      in   1   synchronous reset, active-high
//   an       in   4   anode select, active-low, one-hot-low when meaningful
//   seg      in   8   segments, active-low, bit7..0 = a,b,c,d,e,f,g,dp
//   nb       out  14  last published binary value (0..9999)
//   bcd      out  16  last published digits {thousands,hundreds,tens,units}
//   valid    out  1   1-cycle pulse when nb/bcd update
//   dec_err  out  1   1-cycle pulse when a converted frame held a bad digit
// -----------------------------------------------------------------------------
module segscan_decoder #(
    parameter int SEG_LAG       = 1,
    parameter int STABLE_FRAMES = 2
) (
    input  logic        myclk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [13:0] nb,
    output logic [15:0] bcd,
    output logic        valid,
    output logic        dec_err
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Decimal point carries no digit information.
    logic dp_unused;
    assign dp_unused = seg[0];

    // ------------------------------------------------------------------
    // Anode delay line: realigns the anode code with the segment pattern
    // that trails it by SEG_LAG clocks.
    // ------------------------------------------------------------------
    logic [3:0] an_lag;

    generate
        if (SEG_LAG == 0) begin : g_no_lag
            assign an_lag = an;
        end else begin : g_lag
            logic [3:0] dly_q [SEG_LAG];

            always_ff @(posedge myclk) begin
                if (rst) begin
                    for (int i = 0; i < SEG_LAG; i++) begin
                        dly_q[i] <= 4'b1111;
                    end
                end else begin
                    dly_q[0] <= an;
                    for (int i = 1; i < SEG_LAG; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign an_lag = dly_q[SEG_LAG-1];
        end
    endgenerate

    // Pattern (a..g, active-low) to {bad, digit}. Anything not a decimal
    // digit, including hex letters and blanks, is flagged bad.
    function automatic logic [4:0] seg_to_digit(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b0000001: r = {1'b0, 4'd0};
            7'b1001111: r = {1'b0, 4'd1};
            7'b0010010: r = {1'b0, 4'd2};
            7'b0000110: r = {1'b0, 4'd3};
            7'b1001100: r = {1'b0, 4'd4};
            7'b0100100: r = {1'b0, 4'd5};
            7'b0100000: r = {1'b0, 4'd6};
            7'b0001111: r = {1'b0, 4'd7};
            7'b0000000: r = {1'b0, 4'd8};
            7'b0000100: r = {1'b0, 4'd9};
            default:    r = {1'b1, 4'd0};
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Digit capture and frame assembly. Slot 0 = units ... slot 3 = thousands.
    // ------------------------------------------------------------------
    logic [15:0] slot_q, slot_d;
    logic [3:0]  bad_q, bad_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] pend_dig_q;
    logic [3:0]  pend_bad_q;
    logic        pending_q;
    logic        frame_done;
    logic        cap_hit;
    logic [1:0]  cap_idx;
    logic [4:0]  cap_dec;
    logic        pend_take;

    always_comb begin
        cap_hit = 1'b1;
        cap_idx = 2'd0;
        case (an_lag)
            4'b0111: cap_idx = 2'd0;
            4'b1110: cap_idx = 2'd1;
            4'b1101: cap_idx = 2'd2;
            4'b1011: cap_idx = 2'd3;
            default: cap_hit = 1'b0;
        endcase
        cap_dec = seg_to_digit(seg[7:1]);

        slot_d = slot_q;
        bad_d  = bad_q;
        seen_d = seen_q;
        if (cap_hit) begin
            slot_d[{cap_idx, 2'b00} +: 4] = cap_dec[3:0];
            bad_d[cap_idx]                = cap_dec[4];
            seen_d[cap_idx]               = 1'b1;
        end
        // Completion looks at the post-capture view so the 4th digit lands
        // in the pending buffer on the same edge it is captured.
        frame_done = (seen_d == 4'b1111);
    end

    always_ff @(posedge myclk) begin
        if (rst) begin
            slot_q     <= '0;
            bad_q      <= '0;
            seen_q     <= '0;
            pend_dig_q <= '0;
            pend_bad_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            bad_q  <= bad_d;
            seen_q <= frame_done ? 4'b0000 : seen_d;
            if (frame_done) begin
                pend_dig_q <= slot_d;
                pend_bad_q <= bad_d;
            end
            // A fresh completion wins over the FSM taking the old buffer.
            if (frame_done) begin
                pending_q <= 1'b1;
            end else if (pend_take) begin
                pending_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion / stability FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] conv_dig_q, conv_dig_d;
    logic [3:0]  conv_bad_q, conv_bad_d;
    logic [1:0]  conv_idx_q, conv_idx_d;
    logic [13:0] acc_q, acc_d;
    logic [3:0]  match_cnt_q, match_cnt_d;
    logic [13:0] last_q, last_d;
    logic        published_q, published_d;
    logic [13:0] nb_q, nb_d;
    logic [15:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        dec_err_q, dec_err_d;
    logic [3:0]  cur_digit;

    assign cur_digit = conv_dig_q[{conv_idx_q, 2'b00} +: 4];

    always_comb begin
        state_d     = state_q;
        conv_dig_d  = conv_dig_q;
        conv_bad_d  = conv_bad_q;
        conv_idx_d  = conv_idx_q;
        acc_d       = acc_q;
        match_cnt_d = match_cnt_q;
        last_d      = last_q;
        published_d = published_q;
        nb_d        = nb_q;
        bcd_d       = bcd_q;
        valid_d     = 1'b0;
        dec_err_d   = 1'b0;
        pend_take   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    pend_take  = 1'b1;
                    conv_dig_d = pend_dig_q;
                    conv_bad_d = pend_bad_q;
                    conv_idx_d = 2'd3;      // thousands first
                    acc_d      = '0;
                    state_d    = ST_CONV;
                end
            end

            ST_CONV: begin
                // acc*10 + digit as two shifts and an add.
                acc_d = {acc_q[10:0], 3'b000} + {acc_q[12:0], 1'b0}
                        + {10'd0, cur_digit};
                conv_idx_d = conv_idx_q - 2'd1;
                if (conv_idx_q == 2'd0) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                state_d = ST_IDLE;
                if (|conv_bad_q) begin
                    dec_err_d   = 1'b1;
                    match_cnt_d = '0;
                end else begin
                    if (acc_q == last_q) begin
                        match_cnt_d = (match_cnt_q >= STABLE_CNT) ? STABLE_CNT
                                                                  : match_cnt_q + 4'd1;
                    end else begin
                        match_cnt_d = 4'd1;
                    end
                    last_d = acc_q;
                    if ((match_cnt_d == STABLE_CNT) &&
                        ((acc_q != nb_q) || !published_q)) begin
                        nb_d        = acc_q;
                        bcd_d       = conv_dig_q;
                        valid_d     = 1'b1;
                        published_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge myclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            conv_dig_q  <= '0;
            conv_bad_q  <= '0;
            conv_idx_q  <= '0;
            acc_q       <= '0;
            match_cnt_q <= '0;
            last_q      <= '0;
            published_q <= 1'b0;
            nb_q        <= '0;
            bcd_q       <= '0;
            valid_q     <= 1'b0;
            dec_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            conv_dig_q  <= conv_dig_d;
            conv_bad_q  <= conv_bad_d;
            conv_idx_q  <= conv_idx_d;
            acc_q       <= acc_d;
            match_cnt_q <= match_cnt_d;
            last_q      <= last_d;
            published_q <= published_d;
            nb_q        <= nb_d;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            dec_err_q   <= dec_err_d;
        end
    end

    assign nb      = nb_q;
    assign bcd     = bcd_q;
    assign valid   = valid_q;
    assign dec_err = dec_err_q;

endmodule
